// File: rtl/data_responder.sv
// -----------------------------------------------------------------------------
// data_responder
//   Responder for the processor data port. It answers ReadData/WriteData
//   requests from an internal synchronous RAM and a small memory-mapped I/O
//   bank. It stretches every transfer by WAIT_CYCLES wait states using
//   DataWaitreq.
//
//   The I/O bank holds four registers:
//     16'hF000  LED register (10 bits, read/write)
//     16'hF001  switch input (read-only)
//     16'hF002  hex display word (16 bits, read/write)
//     16'hF003  free-running cycle counter (a write clears it)
//
// Ports
//   Clock        system clock, rising edge
//   Reset        asynchronous active-low reset
//   DataAddr     word address from the processor
//   DataOut      write data from the processor
//   WriteData    write request (wins when ReadData is also high)
//   ReadData     read request
//   DataIn       read data; non-zero only in the completing (DONE) cycle
//   DataWaitreq  stall; the transfer completes in the cycle where it is low
//   SW           board switches
//   LEDR         board LEDs
//   HEX3..HEX0   active-low seven-segment digits, bit0 = segment a
// -----------------------------------------------------------------------------
module data_responder #(
   parameter int WAIT_CYCLES = 1,
   parameter int RAM_AW      = 12
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] DataAddr,
   input  logic [15:0] DataOut,
   input  logic        WriteData,
   input  logic        ReadData,
   output logic [15:0] DataIn,
   output logic        DataWaitreq,
   input  logic [9:0]  SW,
   output logic [9:0]  LEDR,
   output logic [6:0]  HEX3,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX0
);

   localparam logic [15:0] ADDR_LED = 16'hF000;
   localparam logic [15:0] ADDR_SW  = 16'hF001;
   localparam logic [15:0] ADDR_HEX = 16'hF002;
   localparam logic [15:0] ADDR_CYC = 16'hF003;

   // Wait counter load value; unused when no wait states are configured.
   localparam logic [3:0] WCNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Active-low seven-segment pattern for one hex digit.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] seg;
      case (n)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         4'hF:    seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
      return seg;
   endfunction

   state_t      state_q;
   logic [3:0]  wcnt_q;
   logic [15:0] addr_q;
   logic        sel_ram_q;
   logic [15:0] ram_rd_q;
   logic [15:0] mmio_rd_q;
   logic [9:0]  leds_q;
   logic [15:0] hex_q;
   logic [15:0] cyc_q;
   logic [15:0] mem [2**RAM_AW];

   logic        req_s;
   logic        rd_s;
   logic        enter_done_s;
   logic        commit_s;
   logic [15:0] mmio_rd_s;

   assign req_s = ReadData | WriteData;
   // A simultaneous read and write is a write, so it never returns data.
   assign rd_s  = ReadData & ~WriteData;

   // The edge that moves the FSM into DONE is the one that samples the address
   // and the read data.
   assign enter_done_s = ((state_q == ST_IDLE) && req_s && (WAIT_CYCLES == 0)) ||
                         ((state_q == ST_WAIT) && req_s && (wcnt_q == 4'd0));

   // Writes land on the edge that leaves DONE, and only if WriteData is still high.
   assign commit_s = (state_q == ST_DONE) && WriteData;

   // Transfer FSM: IDLE -> (WAIT) -> DONE -> IDLE; a dropped request aborts.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
         wcnt_q  <= 4'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_s) begin
                  if (WAIT_CYCLES == 0) begin
                     state_q <= ST_DONE;
                  end else begin
                     state_q <= ST_WAIT;
                     wcnt_q  <= WCNT_INIT;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (!req_s) begin
                  state_q <= ST_IDLE;
               end else if (wcnt_q == 4'd0) begin
                  state_q <= ST_DONE;
               end else begin
                  wcnt_q <= wcnt_q - 4'd1;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Read mux for the I/O bank; unmapped addresses read as zero.
   always_comb begin
      mmio_rd_s = 16'h0000;
      case (DataAddr)
         ADDR_LED: mmio_rd_s = {6'd0, leds_q};
         ADDR_SW:  mmio_rd_s = {6'd0, SW};
         ADDR_HEX: mmio_rd_s = hex_q;
         ADDR_CYC: mmio_rd_s = cyc_q;
         default:  mmio_rd_s = 16'h0000;
      endcase
   end

   // Capture the address and the I/O read data on entry to DONE.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         addr_q    <= 16'h0000;
         sel_ram_q <= 1'b0;
         mmio_rd_q <= 16'h0000;
      end else if (enter_done_s) begin
         addr_q    <= DataAddr;
         sel_ram_q <= (DataAddr[15:12] == 4'h0);
         mmio_rd_q <= mmio_rd_s;
      end else begin
         addr_q    <= addr_q;
         sel_ram_q <= sel_ram_q;
         mmio_rd_q <= mmio_rd_q;
      end
   end

   // Data RAM: no reset, so it maps onto a block RAM with a registered read port.
   always_ff @(posedge Clock) begin
      if (commit_s && (addr_q[15:12] == 4'h0)) begin
         mem[addr_q[RAM_AW-1:0]] <= DataOut;
      end
      if (enter_done_s) begin
         ram_rd_q <= mem[DataAddr[RAM_AW-1:0]];
      end
   end

   // I/O registers; a committed counter write overrides the increment.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         leds_q <= 10'd0;
         hex_q  <= 16'h0000;
         cyc_q  <= 16'h0000;
      end else begin
         if (commit_s && (addr_q == ADDR_LED)) begin
            leds_q <= DataOut[9:0];
         end
         if (commit_s && (addr_q == ADDR_HEX)) begin
            hex_q <= DataOut;
         end
         if (commit_s && (addr_q == ADDR_CYC)) begin
            cyc_q <= 16'h0000;
         end else begin
            cyc_q <= cyc_q + 16'd1;
         end
      end
   end

   // Read data is only presented in DONE while the read is still requested.
   always_comb begin
      if ((state_q == ST_DONE) && rd_s) begin
         if (sel_ram_q) begin
            DataIn = ram_rd_q;
         end else begin
            DataIn = mmio_rd_q;
         end
      end else begin
         DataIn = 16'h0000;
      end
   end

   // IDLE stalls on a new request combinationally; WAIT always stalls.
   always_comb begin
      case (state_q)
         ST_IDLE: DataWaitreq = req_s;
         ST_WAIT: DataWaitreq = 1'b1;
         ST_DONE: DataWaitreq = 1'b0;
         default: DataWaitreq = 1'b0;
      endcase
   end

   assign LEDR = leds_q;
   assign HEX3 = hex7(hex_q[15:12]);
   assign HEX2 = hex7(hex_q[11:8]);
   assign HEX1 = hex7(hex_q[7:4]);
   assign HEX0 = hex7(hex_q[3:0]);

endmodule

// File: tb/tb_data_responder.sv
// Directed bench for data_responder: a table of transfers on a WAIT_CYCLES=1
// instance plus hand-written abort/reset/zero-wait sequences.
module tb_data_responder;

   localparam int W1 = 1;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic [15:0] DataAddr = 16'h0000;
   logic [15:0] DataOut = 16'h0000;
   logic        WriteData = 1'b0;
   logic        ReadData = 1'b0;
   logic [15:0] DataIn;
   logic        DataWaitreq;
   logic [9:0]  SW = 10'd0;
   logic [9:0]  LEDR;
   logic [6:0]  HEX3, HEX2, HEX1, HEX0;

   // Second instance with no wait states.
   logic [15:0] a0_addr = 16'h0000;
   logic [15:0] a0_dout = 16'h0000;
   logic        a0_wr = 1'b0;
   logic        a0_rd = 1'b0;
   logic [15:0] d0_din;
   logic        d0_wait;
   logic [9:0]  d0_ledr;
   logic [6:0]  d0_h3, d0_h2, d0_h1, d0_h0;

   int checks = 0;
   int errors = 0;
   logic [15:0] edge_cnt;
   logic [15:0] cyc_base = 16'h0000;
   logic [15:0] last_commit = 16'h0000;

   data_responder #(.WAIT_CYCLES(W1), .RAM_AW(12)) dut (
      .Clock(Clock), .Reset(Reset), .DataAddr(DataAddr), .DataOut(DataOut),
      .WriteData(WriteData), .ReadData(ReadData), .DataIn(DataIn),
      .DataWaitreq(DataWaitreq), .SW(SW), .LEDR(LEDR),
      .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0)
   );

   data_responder #(.WAIT_CYCLES(0), .RAM_AW(12)) dut0 (
      .Clock(Clock), .Reset(Reset), .DataAddr(a0_addr), .DataOut(a0_dout),
      .WriteData(a0_wr), .ReadData(a0_rd), .DataIn(d0_din),
      .DataWaitreq(d0_wait), .SW(10'd0), .LEDR(d0_ledr),
      .HEX3(d0_h3), .HEX2(d0_h2), .HEX1(d0_h1), .HEX0(d0_h0)
   );

   always #5 Clock = ~Clock;

   // Reference count of rising edges since reset release (mirrors the
   // architectural cycle counter before any clear).
   always @(posedge Clock or negedge Reset) begin
      if (!Reset) edge_cnt <= 16'h0000;
      else        edge_cnt <= edge_cnt + 16'd1;
   end

   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [9:0]  sw;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input logic [15:0] act, input logic [15:0] exp, input string nm);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Full transfer on the WAIT_CYCLES=1 instance. Entered and left at posedge+1.
   task automatic xfer(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic dyn,
                       input logic [15:0] exp, input string nm);
      logic [15:0] e;
      ReadData = rd; WriteData = wr; DataAddr = addr; DataOut = wdata;
      for (int c = 0; c <= W1; c++) begin
         @(negedge Clock);
         chk({15'd0, DataWaitreq}, 16'd1, {nm, " waitreq_hi"});
         chk(DataIn, 16'h0000, {nm, " din_before"});
         @(posedge Clock); #1;
      end
      @(negedge Clock);
      chk({15'd0, DataWaitreq}, 16'd0, {nm, " waitreq_done"});
      e = dyn ? (edge_cnt - 16'd1 - cyc_base) : exp;
      chk(DataIn, e, {nm, " din_done"});
      @(posedge Clock); #1;
      last_commit = edge_cnt;
      ReadData = 1'b0; WriteData = 1'b0;
      @(negedge Clock);
      chk(DataIn, 16'h0000, {nm, " din_after"});
      @(posedge Clock); #1;
   endtask

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 16'h0005, 16'hBEEF, 10'h2A5, 16'h0000};
      vecs[1]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 10'h2A5, 16'hBEEF};
      vecs[2]  = '{1'b0, 1'b1, 16'hF000, 16'hFFFF, 10'h2A5, 16'h0000};
      vecs[3]  = '{1'b1, 1'b0, 16'hF000, 16'h0000, 10'h2A5, 16'h03FF};
      vecs[4]  = '{1'b1, 1'b0, 16'hF001, 16'h0000, 10'h2A5, 16'h02A5};
      vecs[5]  = '{1'b0, 1'b1, 16'hF002, 16'h12AF, 10'h2A5, 16'h0000};
      vecs[6]  = '{1'b1, 1'b0, 16'hF002, 16'h0000, 10'h2A5, 16'h12AF};
      vecs[7]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, 10'h2A5, 16'h0000};
      vecs[8]  = '{1'b0, 1'b1, 16'h0020, 16'h0000, 10'h2A5, 16'h0000};
      vecs[9]  = '{1'b1, 1'b0, 16'h1005, 16'h0000, 10'h2A5, 16'h0000};
      vecs[10] = '{1'b0, 1'b1, 16'hF001, 16'h0000, 10'h155, 16'h0000};
      vecs[11] = '{1'b1, 1'b0, 16'hF001, 16'h0000, 10'h155, 16'h0155};

      // Reset state
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b1;
      cyc_base = 16'h0000;
      @(negedge Clock);
      chk({15'd0, DataWaitreq}, 16'd0, "rst waitreq");
      chk(DataIn, 16'h0000, "rst din");
      chk({6'd0, LEDR}, 16'h0000, "rst ledr");
      chk({2'd0, HEX3, HEX2}, {2'd0, 7'h40, 7'h40}, "rst hex32");
      chk({2'd0, HEX1, HEX0}, {2'd0, 7'h40, 7'h40}, "rst hex10");
      @(posedge Clock); #1;

      xfer(1'b1, 1'b0, 16'hF003, 16'h0000, 1'b1, 16'h0000, "cyc_read0");

      for (int i = 0; i < 12; i++) begin
         SW = vecs[i].sw;
         xfer(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0,
              vecs[i].exp, $sformatf("vec%0d", i));
      end

      chk({6'd0, LEDR}, 16'h03FF, "ledr_3ff");
      chk({2'd0, HEX3, HEX2}, {2'd0, 7'h79, 7'h24}, "hex32_12");
      chk({2'd0, HEX1, HEX0}, {2'd0, 7'h08, 7'h0E}, "hex10_af");

      // Counter clear on write, then readback relative to the clear edge
      xfer(1'b0, 1'b1, 16'hF003, 16'h5555, 1'b0, 16'h0000, "cyc_clr");
      cyc_base = last_commit;
      xfer(1'b1, 1'b0, 16'hF003, 16'h0000, 1'b1, 16'h0000, "cyc_read1");

      // Abort: WriteData dropped during WAIT
      WriteData = 1'b1; DataAddr = 16'h0010; DataOut = 16'h1234;
      @(negedge Clock);
      chk({15'd0, DataWaitreq}, 16'd1, "abort waitreq_n");
      @(posedge Clock); #1;
      WriteData = 1'b0;
      @(posedge Clock); #1;
      @(negedge Clock);
      chk({15'd0, DataWaitreq}, 16'd0, "abort waitreq_lo");
      chk(DataIn, 16'h0000, "abort din");
      @(posedge Clock); #1;
      xfer(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, "abort_rd");

      // Reset asserted in WAIT
      WriteData = 1'b1; DataAddr = 16'h0010; DataOut = 16'h1234;
      @(posedge Clock); #1;
      Reset = 1'b0;
      WriteData = 1'b0;
      @(negedge Clock);
      chk({15'd0, DataWaitreq}, 16'd0, "midrst waitreq");
      chk({6'd0, LEDR}, 16'h0000, "midrst ledr");
      chk({2'd0, HEX1, HEX0}, {2'd0, 7'h40, 7'h40}, "midrst hex10");
      @(negedge Clock);
      Reset = 1'b1;
      cyc_base = 16'h0000;
      @(posedge Clock); #1;
      xfer(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, "midrst_rd");

      // Read+write together is a write
      xfer(1'b1, 1'b1, 16'h0020, 16'h00AA, 1'b0, 16'h0000, "both");
      xfer(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h00AA, "both_rd");
      xfer(1'b1, 1'b0, 16'h8000, 16'h0000, 1'b0, 16'h0000, "unmapped");

      // Zero wait states: write then back-to-back read, 2 cycles each
      a0_wr = 1'b1; a0_addr = 16'h0003; a0_dout = 16'h5A5A;
      @(negedge Clock);
      chk({15'd0, d0_wait}, 16'd1, "w0 wr waitreq_hi");
      @(posedge Clock); #1;
      @(negedge Clock);
      chk({15'd0, d0_wait}, 16'd0, "w0 wr waitreq_done");
      chk(d0_din, 16'h0000, "w0 wr din");
      @(posedge Clock); #1;
      a0_wr = 1'b0; a0_rd = 1'b1;
      @(negedge Clock);
      chk({15'd0, d0_wait}, 16'd1, "w0 rd waitreq_hi");
      chk(d0_din, 16'h0000, "w0 rd din_before");
      @(posedge Clock); #1;
      @(negedge Clock);
      chk({15'd0, d0_wait}, 16'd0, "w0 rd waitreq_done");
      chk(d0_din, 16'h5A5A, "w0 rd din_done");
      @(posedge Clock); #1;
      a0_rd = 1'b0;
      @(negedge Clock);
      chk(d0_din, 16'h0000, "w0 rd din_after");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_responder.md
Name: data_responder

Overview:
- Responder end of the processor's data port: the processor initiates on ReadData/WriteData and this block answers.
- Contains an internal synchronous data RAM plus a small memory-mapped I/O register bank (LEDs, switches, a hex display word, a cycle counter).
- Inserts a configurable number of wait states by driving DataWaitreq.
- Sits between the processor core and the board I/O; replaces a bare RAM on the data side.

Parameters:
- WAIT_CYCLES, 1, extra wait cycles per transfer (0..15).
- RAM_AW, 12, RAM address width; RAM holds 2^RAM_AW 16-bit words.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- DataAddr  input  16  word address from processor.
- DataOut  input  16  write data from processor.
- WriteData  input  1  write request.
- ReadData  input  1  read request.
- DataIn  output  16  read data to processor.
- DataWaitreq  output  1  stall; the transfer completes only in a cycle where it is low.
- SW  input  10  board switches.
- LEDR  output  10  board LEDs.
- HEX3, HEX2, HEX1, HEX0  output  7 each  active-low seven-segment digits, bit0 = segment a.

Behaviour:
- Reset is asynchronous and active-low:
  - FSM to IDLE; LEDR=0; hex word=0, so every HEX output=7'h40 ("0"); cycle counter=0.
  - DataIn=0; DataWaitreq=0.
  - RAM contents are not reset.
- req = ReadData | WriteData. If both are asserted, the transfer is a write and DataIn stays 0.
- FSM has three states: IDLE, WAIT, DONE.
  - IDLE: DataWaitreq = req, combinational. If req, go to WAIT with cnt=WAIT_CYCLES-1, or to DONE if WAIT_CYCLES==0.
  - WAIT: DataWaitreq=1. If cnt==0 go to DONE, else decrement cnt.
  - DONE: DataWaitreq=0. Always return to IDLE.
- Timing: a request first present in cycle N sees DataWaitreq high in cycles N..N+WAIT_CYCLES and low in cycle N+WAIT_CYCLES+1 (DONE).
- Back-to-back: a request held at N+WAIT_CYCLES+2 starts a new transfer with no extra bubble.
- Abort: if req drops while in WAIT or DONE, go to IDLE immediately. Nothing is committed, and DataIn=0.
- Reads:
  - The RAM/MMIO address is sampled at the edge entering DONE.
  - DataIn carries read data only in DONE and is 16'h0000 in every other cycle.
- Writes: committed at the edge ending DONE, provided WriteData is still high.
- Address decode:
  - DataAddr[15:12]==4'h0 selects RAM word DataAddr[RAM_AW-1:0]. Bits above RAM_AW are ignored.
  - 16'hF000 LEDR: read/write. Only DataOut[9:0] is stored; reads return zero-extended.
  - 16'hF001 SW: read-only; returns zero-extended SW, sampled at the DONE-entry edge. Writes are ignored.
  - 16'hF002 hex word: read/write, 16 bits. Nibble k drives HEXk through a 0-F decoder.
  - 16'hF003 cycle counter: increments every clock and wraps 16'hFFFF→0. Reads return its value at the DONE-entry edge. A committed write clears it to 0; the clear wins over the increment in that cycle.
  - Any other address: reads return 0; writes are ignored. The transfer still takes the full latency.
- Protocol: DataAddr and DataOut must be stable while DataWaitreq is high. Changes are not checked; the sampled values are used.
- Reset asserted mid-transfer: FSM to IDLE and no commit. On reset release, a still-present request restarts from cycle N.
- Hex decoder values: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).

Test Plan:
- Reset released with no request -> DataWaitreq=0, DataIn=0, LEDR=0, HEX0..HEX3=7'h40; cycle counter increments from 0.
- WAIT_CYCLES=1: write 16'hBEEF to 16'h0005, then read 16'h0005 -> DataWaitreq high for 2 cycles on each transfer; DataIn=16'hBEEF in the read's 3rd cycle and 0 before and after.
- Write 16'hFFFF to 16'hF000 -> LEDR=10'h3FF after the commit edge. Read 16'hF000 -> 16'h03FF. With SW=10'h2A5, read 16'hF001 -> 16'h02A5.
- Write 16'h12AF to 16'hF002 -> HEX3=7'h79, HEX2=7'h24, HEX1=7'h08, HEX0=7'h0E. Read 16'hF002 -> 16'h12AF.
- Start a write of 16'h1234 to 16'h0010 (RAM previously 16'h0000) and drop WriteData during WAIT -> DataWaitreq low the next cycle; a later read of 16'h0010 returns 16'h0000.
- Repeat the same write but assert Reset in WAIT -> no commit. ReadData+WriteData together to 16'h0020 with DataOut=16'h00AA -> treated as a write and DataIn=0 in DONE; a later read of 16'h0020 returns 16'h00AA. Read 16'h8000 -> 16'h0000 after the full latency. With WAIT_CYCLES=0, a read completes in 2 cycles.
